// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and lane helpers for the data memory controller.
// Contents: access-size enum, controller FSM state enum, lane/alignment/extension
// helpers used by data_mem_ctrl.
package dmem_pkg;

  localparam int unsigned DMEM_DW    = 32;
  localparam int unsigned DMEM_LANES = 4;

  typedef enum logic [1:0] {
    BYTE    = 2'b00,
    HALF    = 2'b01,
    WORD    = 2'b10,
    ILLEGAL = 2'b11
  } dmem_size_e;

  typedef enum logic [1:0] {
    CLEAR = 2'b00,
    IDLE  = 2'b01,
    RESP  = 2'b10
  } dmem_state_e;

  // Misaligned half/word or the reserved size code.
  function automatic logic access_err(dmem_size_e sz, logic [1:0] off);
    case (sz)
      BYTE:    access_err = 1'b0;
      HALF:    access_err = off[0];
      WORD:    access_err = (off != 2'b00);
      default: access_err = 1'b1;
    endcase
  endfunction

  // Byte-lane write enables for an aligned access.
  function automatic logic [DMEM_LANES-1:0] lane_mask(dmem_size_e sz, logic [1:0] off);
    case (sz)
      BYTE:    lane_mask = 4'b0001 << off;
      HALF:    lane_mask = off[1] ? 4'b1100 : 4'b0011;
      WORD:    lane_mask = 4'b1111;
      default: lane_mask = 4'b0000;
    endcase
  endfunction

  // Replicate right-aligned store data so every candidate lane carries it.
  function automatic logic [DMEM_DW-1:0] store_align(dmem_size_e sz, logic [DMEM_DW-1:0] wd);
    case (sz)
      BYTE:    store_align = {4{wd[7:0]}};
      HALF:    store_align = {2{wd[15:0]}};
      default: store_align = wd;
    endcase
  endfunction

  // Pick the addressed lane(s) from a RAM word and sign/zero extend.
  function automatic logic [DMEM_DW-1:0] load_extract(dmem_size_e sz, logic [1:0] off,
                                                      logic uns, logic [DMEM_DW-1:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (sz)
      BYTE:    load_extract = {{24{b[7] & ~uns}}, b};
      HALF:    load_extract = {{16{h[15] & ~uns}}, h};
      default: load_extract = word;
    endcase
  endfunction

endpackage

// File: rtl/dmem_ram_bank.sv
// dmem_ram_bank: single-port 32-bit RAM with per-byte write enables and a
// registered read port (read happens only on enabled cycles with no lane written,
// so the read register holds its value otherwise).
// Ports: clk_i clock; en_i access enable; we_i byte write enables; addr_i word
// index; wdata_i write data; rdata_o registered read data.
module dmem_ram_bank #(
  parameter int unsigned AW = 14
) (
  input  logic          clk_i,
  input  logic          en_i,
  input  logic [3:0]    we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  localparam int unsigned DEPTH = 2 ** AW;

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      for (int b = 0; b < 4; b++) begin
        if (we_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
      if (we_i == 4'b0000) rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: byte/half/word load-store controller in front of a 32-bit RAM,
// valid/ready request and response channels, one-cycle response latency.
// Optional feature: define DMEM_CLEAR_EN to zero the whole RAM after reset
// (one word per cycle, requests blocked during the sweep).
// Ports: CLK/RST clock and synchronous active-high reset; REQ_* request channel
// (VALID/READY handshake, WE, SIZE, UNSIGNED, byte ADDR, right-aligned WDATA);
// RSP_* response channel (VALID/READY handshake, RDATA, ERR).
module data_mem_ctrl
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  REQ_VALID,
  output logic                  REQ_READY,
  input  logic                  REQ_WE,
  input  logic [1:0]            REQ_SIZE,
  input  logic                  REQ_UNSIGNED,
  input  logic [ADDR_WIDTH-1:0] REQ_ADDR,
  input  logic [DATA_WIDTH-1:0] REQ_WDATA,
  output logic                  RSP_VALID,
  input  logic                  RSP_READY,
  output logic [DATA_WIDTH-1:0] RSP_RDATA,
  output logic                  RSP_ERR
);

  localparam int unsigned WAW = ADDR_WIDTH - 2;

  dmem_state_e     state_q;
  dmem_size_e      req_size;
  dmem_size_e      sz_q;
  logic [1:0]      off_q;
  logic            uns_q;
  logic            load_ok_q;
  logic            err_q;
  logic            accept;
  logic            req_err;
  logic            ram_en;
  logic [3:0]      ram_we;
  logic [WAW-1:0]  ram_addr;
  logic [31:0]     ram_wdata;
  logic [31:0]     ram_rdata;
`ifdef DMEM_CLEAR_EN
  logic [WAW-1:0]  clr_cnt_q;
`endif

  assign req_size  = dmem_size_e'(REQ_SIZE);
  assign req_err   = access_err(req_size, REQ_ADDR[1:0]);
  assign RSP_VALID = (state_q == RESP);
  assign REQ_READY = !RST && (state_q != CLEAR) && (!RSP_VALID || RSP_READY);
  assign accept    = REQ_VALID && REQ_READY;

  // RAM port: request path, overridden by the clear sweep.
  always_comb begin
    ram_en    = accept;
    ram_we    = (accept && REQ_WE && !req_err) ? lane_mask(req_size, REQ_ADDR[1:0]) : 4'b0000;
    ram_addr  = REQ_ADDR[ADDR_WIDTH-1:2];
    ram_wdata = store_align(req_size, REQ_WDATA);
`ifdef DMEM_CLEAR_EN
    if (state_q == CLEAR && !RST) begin
      ram_en    = 1'b1;
      ram_we    = 4'b1111;
      ram_addr  = clr_cnt_q;
      ram_wdata = '0;
    end
`endif
  end

  dmem_ram_bank #(.AW(WAW)) u_ram (
    .clk_i   (CLK),
    .en_i    (ram_en),
    .we_i    (ram_we),
    .addr_i  (ram_addr),
    .wdata_i (ram_wdata),
    .rdata_o (ram_rdata)
  );

  // Control FSM; response metadata captured at accept, held through a stall.
  always_ff @(posedge CLK) begin
    if (RST) begin
`ifdef DMEM_CLEAR_EN
      state_q   <= CLEAR;
      clr_cnt_q <= '0;
`else
      state_q   <= IDLE;
`endif
      load_ok_q <= 1'b0;
      err_q     <= 1'b0;
      sz_q      <= WORD;
      off_q     <= 2'b00;
      uns_q     <= 1'b0;
    end else begin
      case (state_q)
`ifdef DMEM_CLEAR_EN
        CLEAR: begin
          clr_cnt_q <= clr_cnt_q + WAW'(1);
          if (clr_cnt_q == '1) state_q <= IDLE;
        end
`endif
        IDLE, RESP: begin
          if (accept) begin
            state_q   <= RESP;
            load_ok_q <= !REQ_WE && !req_err;
            err_q     <= req_err;
            sz_q      <= req_size;
            off_q     <= REQ_ADDR[1:0];
            uns_q     <= REQ_UNSIGNED;
          end else if (RSP_READY) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Only successful loads carry data; stores and errors answer with zero.
  assign RSP_RDATA = load_ok_q ? load_extract(sz_q, off_q, uns_q, ram_rdata) : '0;
  assign RSP_ERR   = err_q;

endmodule

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 16, byte-address width; capacity = 2**ADDR_WIDTH bytes, 2**(ADDR_WIDTH-2) 32-bit words.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, fixed at 32, four byte lanes.
REQ-003 SHALL have port CLK, input, 1, the single clock, rising-edge.
REQ-004 SHALL have port RST, input, 1; reset is synchronous and active-high.
REQ-005 SHALL have port REQ_VALID, input, 1, request present.
REQ-006 SHALL have port REQ_READY, output, 1, request accepted when REQ_VALID and REQ_READY are both high at a rising edge.
REQ-007 SHALL have port REQ_WE, input, 1: 1 = store, 0 = load.
REQ-008 SHALL have port REQ_SIZE, input, 2: 00 byte, 01 half, 10 word, 11 illegal.
REQ-009 SHALL have port REQ_UNSIGNED, input, 1, load zero-extend when 1, sign-extend when 0.
REQ-010 SHALL have ports REQ_ADDR (input, ADDR_WIDTH, byte address) and REQ_WDATA (input, 32, store data, right-aligned).
REQ-011 SHALL have ports RSP_VALID (output, 1), RSP_READY (input, 1), RSP_RDATA (output, 32) and RSP_ERR (output, 1, misaligned or illegal access).

Function
REQ-012 SHALL use FSM states CLEAR, IDLE and RESP; REQ_READY = (state != CLEAR) && (!RSP_VALID || RSP_READY).
REQ-013 SHALL, for a request accepted at edge N, assert RSP_VALID after edge N (one-cycle latency); back-to-back requests SHALL give one response per cycle while RSP_READY is high.
REQ-014 SHALL hold RSP_VALID, RSP_RDATA and RSP_ERR stable while RSP_VALID && !RSP_READY; RESP is left only on RSP_READY.
REQ-015 SHALL, on a store, write only the addressed lanes: byte lane ADDR[1:0], half lanes {ADDR[1],0}+{0,1}, word all lanes; source data is REQ_WDATA[7:0] / [15:0] / [31:0].
REQ-016 SHALL, on a load, extract the addressed lane(s) and extend from bit 7 (byte) or bit 15 (half) unless REQ_UNSIGNED; a word load ignores REQ_UNSIGNED.
REQ-017 SHALL flag misalignment (half with ADDR[0]=1, word with ADDR[1:0]!=0) and REQ_SIZE=11 as errors: no memory write, RSP_ERR=1, RSP_RDATA=0.
REQ-018 SHALL, on a store response, return RSP_RDATA=0 and RSP_ERR=0.
REQ-019 SHALL return the new data for a load accepted the cycle after a store to the same word.
REQ-020 SHALL ignore REQ_ADDR bits outside the word index and byte offset; there is no out-of-range error.

Reset
REQ-021 SHALL, on RST, set RSP_VALID=0, RSP_RDATA=0 and RSP_ERR=0, and set the state to CLEAR (macro on) or IDLE (macro off).
REQ-022 SHALL drop any pending response on RST without it being delivered; RST during CLEAR SHALL restart the clear counter from word 0.
REQ-023 SHALL hold REQ_READY=0 during the RST cycle.

Configuration
REQ-024 SHALL support macro DMEM_CLEAR_EN; when it is defined, the block SHALL sweep the clear counter from 0 to 2**(ADDR_WIDTH-2)-1 after reset, writing 0 to one word per cycle, then enter IDLE; REQ_READY SHALL be 0 throughout the sweep.
REQ-025 SHALL, when DMEM_CLEAR_EN is undefined, omit the CLEAR state and counter, enter IDLE directly from reset, and leave memory contents unspecified.

Structure
REQ-026 SHALL place the size enum (BYTE/HALF/WORD/ILLEGAL) and the FSM state enum in shared package dmem_pkg.
REQ-027 SHALL use one sub-module, dmem_ram_bank: a single-port, block-inferable RAM with 4-bit byte write enables and a registered read port.

Verification
REQ-028 SHALL verify: store word 0xDEADBEEF @0x0010, then byte load @0x0013 signed -> RSP_RDATA=0xFFFFFFDE, RSP_ERR=0.
REQ-029 SHALL verify: store byte 0x7F @0x0021 over word 0x11223344 @0x0020, then word load -> 0x11227F44.
REQ-030 SHALL verify: half load @0x0031 -> RSP_ERR=1, RSP_RDATA=0; a following word load @0x0030 shows the contents unchanged.
REQ-031 SHALL verify: hold RSP_READY=0 for 3 cycles after a load -> REQ_READY=0 and RSP_* stable; raise RSP_READY -> the next request is accepted that same cycle.
REQ-032 SHALL verify: with DMEM_CLEAR_EN and ADDR_WIDTH=6, REQ_READY is low for 16 cycles after reset and a load @0x003C then returns 0.
REQ-033 SHALL verify: assert RST mid-clear at word 5 -> the sweep restarts at word 0 and REQ_READY rises after the full 16 cycles.
